// File: rtl/register_file_nport_pkg.sv
// Shared register-file definitions: sequencer state encoding and the default
// datapath widths also used by the ALU and decode stages.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/register_file_nport_read_port.sv
// One register-file read port: address-0 masking, write bypass and an
// optional output register selected by READ_REG.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          READ_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_c;
  logic [DATA_W-1:0] data_q;

  // Zero-register masking takes precedence over bypass; nothing is visible while clearing.
  always_comb begin
    data_c = '0;
    if (ready) begin
      if (ZERO_REG && (addr == '0)) begin
        data_c = '0;
      end else if (BYPASS && wr_en && (wr_addr == addr)) begin
        data_c = wr_data;
      end else begin
        data_c = mem_data;
      end
    end
  end

  // Output register; left unloaded and pruned when READ_REG is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_c;
    end
  end

  assign data = READ_REG ? data_q : data_c;

endmodule

// File: rtl/register_file_nport.sv
// General-purpose register bank: parametrised array with two independent read
// ports, one write port and a post-reset clear sweep instead of a parallel reset.
module register_file_nport
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter bit                READ_REG   = 1'b0,
  parameter bit                BYPASS     = 1'b1,
  parameter bit                ZERO_REG   = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddrA,
  input  logic [ADDR_W-1:0] readAddrB,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic              write,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_c;
  logic              user_we_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      sweep_cnt <= sweep_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    if ((state == ST_CLEAR) && (sweep_cnt == ADDR_W'(DEPTH - 1))) begin
      state_next = ST_READY;
    end
  end

  // The array write port is shared between the clear sweep and user writes.
  always_comb begin
    busy        = (state == ST_CLEAR);
    ready_c     = 1'b0;
    user_we_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = sweep_cnt;
    mem_wdata_c = INIT_VALUE;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we_c = 1'b1;
      end else begin
        ready_c     = 1'b1;
        user_we_c   = write;
        mem_we_c    = write && !(ZERO_REG && (writeAddr == '0));
        mem_waddr_c = writeAddr;
        mem_wdata_c = writeData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .READ_REG(READ_REG),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready_c),
    .addr    (readAddrA),
    .mem_data(mem[readAddrA]),
    .wr_en   (user_we_c),
    .wr_addr (writeAddr),
    .wr_data (writeData),
    .data    (readDataA)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .READ_REG(READ_REG),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready_c),
    .addr    (readAddrB),
    .mem_data(mem[readAddrB]),
    .wr_en   (user_we_c),
    .wr_addr (writeAddr),
    .wr_data (writeData),
    .data    (readDataB)
  );

endmodule

// File: tb/tb_register_file_nport.sv
// Bench for register_file_nport: five 16x16 variants share one stimulus stream,
// plus a 32x32 variant with a non-zero init value, all checked against a reference model.
module tb_register_file_nport;

  // Per-variant configuration for the 16x16 group (bit k = instance k).
  localparam bit [4:0] RR_CFG = 5'b01100;
  localparam bit [4:0] BP_CFG = 5'b10101;
  localparam bit [4:0] ZR_CFG = 5'b10000;
  localparam logic [31:0] INIT5 = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic [3:0]  ra, rb, wa;
  logic        we;
  logic [15:0] wd;
  logic [15:0] qa [5];
  logic [15:0] qb [5];
  logic        bsy [5];

  logic        reset5;
  logic [4:0]  ra5, rb5, wa5;
  logic        we5;
  logic [31:0] wd5, qa5, qb5;
  logic        bsy5;

  int total = 0;
  int bad   = 0;

  // Reference state: array contents and remaining clear-sweep cycles.
  logic [15:0] m1 [16];
  int          left1 = 16;
  logic [15:0] qa_exp [5];
  logic [15:0] qb_exp [5];
  logic [31:0] m2 [32];
  int          left2 = 32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_file_nport #(.READ_REG(1'b0), .BYPASS(1'b1), .ZERO_REG(1'b0)) d0 (
    .clk(clk), .reset(reset), .readAddrA(ra), .readAddrB(rb), .writeAddr(wa), .write(we),
    .writeData(wd), .readDataA(qa[0]), .readDataB(qb[0]), .busy(bsy[0]));
  register_file_nport #(.READ_REG(1'b0), .BYPASS(1'b0), .ZERO_REG(1'b0)) d1 (
    .clk(clk), .reset(reset), .readAddrA(ra), .readAddrB(rb), .writeAddr(wa), .write(we),
    .writeData(wd), .readDataA(qa[1]), .readDataB(qb[1]), .busy(bsy[1]));
  register_file_nport #(.READ_REG(1'b1), .BYPASS(1'b1), .ZERO_REG(1'b0)) d2 (
    .clk(clk), .reset(reset), .readAddrA(ra), .readAddrB(rb), .writeAddr(wa), .write(we),
    .writeData(wd), .readDataA(qa[2]), .readDataB(qb[2]), .busy(bsy[2]));
  register_file_nport #(.READ_REG(1'b1), .BYPASS(1'b0), .ZERO_REG(1'b0)) d3 (
    .clk(clk), .reset(reset), .readAddrA(ra), .readAddrB(rb), .writeAddr(wa), .write(we),
    .writeData(wd), .readDataA(qa[3]), .readDataB(qb[3]), .busy(bsy[3]));
  register_file_nport #(.READ_REG(1'b0), .BYPASS(1'b1), .ZERO_REG(1'b1)) d4 (
    .clk(clk), .reset(reset), .readAddrA(ra), .readAddrB(rb), .writeAddr(wa), .write(we),
    .writeData(wd), .readDataA(qa[4]), .readDataB(qb[4]), .busy(bsy[4]));
  register_file_nport #(.DATA_W(32), .ADDR_W(5), .INIT_VALUE(INIT5)) d5 (
    .clk(clk), .reset(reset5), .readAddrA(ra5), .readAddrB(rb5), .writeAddr(wa5), .write(we5),
    .writeData(wd5), .readDataA(qa5), .readDataB(qb5), .busy(bsy5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Value a read of address a should produce this cycle, before any clocking.
  function automatic logic [15:0] look1(int k, logic [3:0] a);
    if (left1 != 0) return 16'h0;
    if (ZR_CFG[k] && (a == 4'd0)) return 16'h0;
    if (BP_CFG[k] && we && (wa == a)) return wd;
    return m1[a];
  endfunction

  function automatic logic [31:0] look2(logic [4:0] a);
    if (left2 != 0) return 32'h0;
    if (we5 && (wa5 == a)) return wd5;
    return m2[a];
  endfunction

  // One clock cycle: inputs were set at the falling edge; check, clock, advance model.
  task automatic step();
    logic [15:0] na [5];
    logic [15:0] nb [5];
    #1;
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(left1 != 0));
        check($sformatf("A%0d", k), 32'(qa[k]), 32'(RR_CFG[k] ? qa_exp[k] : look1(k, ra)));
        check($sformatf("B%0d", k), 32'(qb[k]), 32'(RR_CFG[k] ? qb_exp[k] : look1(k, rb)));
      end
    end
    if (!reset5) begin
      check("busy5", 32'(bsy5), 32'(left2 != 0));
      check("A5", qa5, look2(ra5));
      check("B5", qb5, look2(rb5));
    end
    for (int k = 0; k < 5; k++) begin
      na[k] = reset ? 16'h0 : look1(k, ra);
      nb[k] = reset ? 16'h0 : look1(k, rb);
    end
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      qa_exp[k] = na[k];
      qb_exp[k] = nb[k];
    end
    if (reset) begin
      left1 = 16;
    end else if (left1 != 0) begin
      left1--;
      if (left1 == 0) foreach (m1[i]) m1[i] = 16'h0;
    end else if (we) begin
      m1[wa] = wd;
    end
    if (reset5) begin
      left2 = 32;
    end else if (left2 != 0) begin
      left2--;
      if (left2 == 0) foreach (m2[i]) m2[i] = INIT5;
    end else if (we5) begin
      m2[wa5] = wd5;
    end
    @(negedge clk);
  endtask

  task automatic set1(input logic r, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] w_a, input logic w_en, input logic [15:0] w_d);
    reset = r; ra = a; rb = b; wa = w_a; we = w_en; wd = w_d;
  endtask

  task automatic rand1(input bit allow_rst);
    reset = allow_rst && ($urandom_range(63) == 0);
    wa = 4'($urandom);
    we = 1'($urandom);
    wd = 16'($urandom);
    ra = ($urandom_range(2) == 0) ? wa : 4'($urandom);
    rb = ($urandom_range(2) == 0) ? wa : 4'($urandom);
  endtask

  task automatic rand2(input bit allow_rst);
    reset5 = allow_rst && ($urandom_range(63) == 0);
    wa5 = 5'($urandom);
    we5 = 1'($urandom);
    wd5 = $urandom;
    ra5 = ($urandom_range(2) == 0) ? wa5 : 5'($urandom);
    rb5 = ($urandom_range(2) == 0) ? wa5 : 5'($urandom);
  endtask

  initial begin
    foreach (qa_exp[k]) begin
      qa_exp[k] = 16'h0;
      qb_exp[k] = 16'h0;
    end
    set1(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
    rand2(1'b0);
    reset5 = 1'b1;
    for (int c = 0; c < 5; c++) step();

    // Clear sweep; a write during busy must be dropped.
    for (int c = 0; c < 16; c++) begin
      rand2(1'b0);
      set1(1'b0, 4'd3, 4'(c), 4'd3, (c == 4), 16'hBEEF);
      step();
    end
    rand2(1'b0); set1(1'b0, 4'd3, 4'd3, 4'd0, 1'b0, 16'h0); step();

    // Walking write then crossed reads.
    for (int i = 0; i < 16; i++) begin
      rand2(1'b0); set1(1'b0, 4'(i), 4'(15 - i), 4'(i), 1'b1, 16'(i * 16'h1111)); step();
    end
    for (int i = 0; i < 16; i++) begin
      rand2(1'b0); set1(1'b0, 4'(i), 4'(15 - i), 4'd0, 1'b0, 16'h0); step();
    end

    // Bypass on combinational and registered ports, then the zero register.
    rand2(1'b0); set1(1'b0, 4'd5, 4'd5, 4'd5, 1'b1, 16'h0000); step();
    rand2(1'b0); set1(1'b0, 4'd5, 4'd0, 4'd5, 1'b1, 16'h1234); step();
    rand2(1'b0); set1(1'b0, 4'd5, 4'd5, 4'd0, 1'b0, 16'h0); step(); step();
    rand2(1'b0); set1(1'b0, 4'd0, 4'd0, 4'd7, 1'b1, 16'hAAAA); step();
    rand2(1'b0); set1(1'b0, 4'd0, 4'd7, 4'd7, 1'b1, 16'h5555); step();
    rand2(1'b0); set1(1'b0, 4'd0, 4'd7, 4'd0, 1'b0, 16'h0); step(); step();
    rand2(1'b0); set1(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 16'hFFFF); step();
    rand2(1'b0); set1(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0); step(); step();
    rand2(1'b0); set1(1'b0, 4'd1, 4'd0, 4'd1, 1'b1, 16'h0001); step();
    rand2(1'b0); set1(1'b0, 4'd1, 4'd1, 4'd0, 1'b0, 16'h0); step(); step();

    // Wide variant: reset after data was written, re-reset at sweep cycle 10, full re-init.
    for (int c = 0; c < 77; c++) begin
      rand1(1'b1);
      rand2(1'b0);
      reset5 = (c < 2) || (c == 12);
      if (c >= 45) begin
        ra5 = 5'(c - 45);
        rb5 = 5'(76 - c);
        we5 = 1'b0;
      end
      step();
    end

    // Free-running random traffic with occasional resets on both groups.
    for (int c = 0; c < 600; c++) begin
      rand1(1'b1);
      rand2(1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
